// File: rtl/final_adder_pkg.sv
// Shared constants and result type for the final carry-lookahead adder.
package final_adder_pkg;

    localparam int DEF_WIDTH = 10;  // operand and sum width
    localparam int DEF_GROUP = 4;   // first-level lookahead group size

    // Result at the default width: carry out above the WIDTH-bit sum.
    typedef struct packed {
        logic                 carry_out;
        logic [DEF_WIDTH-1:0] s;
    } sum_t;

endpackage

// File: rtl/final_adder_cla_group.sv
// N-bit carry-lookahead block: every carry is a flat sum-of-products of the
// generate/propagate terms and cin, so no carry ripples bit to bit.
// The same block serves as the second level over group G/P terms.
module cla_group #(
    parameter int N = 4
) (
    input  logic [N-1:0] g_i,
    input  logic [N-1:0] p_i,
    input  logic         cin_i,
    output logic [N-1:0] c_o,   // carry into each bit, c_o[0] = cin_i
    output logic         gg_o,  // group generate
    output logic         gp_o   // group propagate
);

    logic acc;
    logic term;

    // Expanded lookahead: c[i] = cin&p[0..i-1] | OR_j g[j]&p[j+1..i-1].
    always_comb begin
        c_o  = '0;
        gg_o = 1'b0;
        acc  = 1'b0;
        term = 1'b0;
        for (int i = 0; i < N; i++) begin
            acc = cin_i;
            for (int j = 0; j < i; j++) acc = acc & p_i[j];
            for (int j = 0; j < i; j++) begin
                term = g_i[j];
                for (int k = j + 1; k < i; k++) term = term & p_i[k];
                acc = acc | term;
            end
            c_o[i] = acc;
        end
        // Group generate does not depend on cin, so it is formed separately.
        for (int j = 0; j < N; j++) begin
            term = g_i[j];
            for (int k = j + 1; k < N; k++) term = term & p_i[k];
            gg_o = gg_o | term;
        end
        gp_o = &p_i;
    end

endmodule

// File: rtl/final_adder.sv
// Two-level carry-lookahead adder with one output register stage.
// Groups are cut from the LSB; the top group takes the remainder bits.
module final_adder
    import final_adder_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int GROUP = DEF_GROUP
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             in_valid,
    output logic [WIDTH-1:0] s,
    output logic             carry_out,
    output logic             out_valid
);

    localparam int   NG   = (WIDTH + GROUP - 1) / GROUP;
    localparam int   LAST = WIDTH - (NG - 1) * GROUP;
    localparam logic CIN  = 1'b0;

    typedef struct packed {
        logic             carry_out;
        logic [WIDTH-1:0] s;
    } res_t;

    logic [WIDTH-1:0] g, p, c;
    logic [NG-1:0]    grp_g, grp_p, grp_c;
    logic             top_g, top_p;
    res_t             res_d, res_q;
    logic             vld_q;

    assign g = a & b;
    assign p = a ^ b;

    // First level: one lookahead block per group, carry-in from level two.
    for (genvar gi = 0; gi < NG; gi++) begin : g_grp
        localparam int N = (gi == NG - 1) ? LAST : GROUP;
        cla_group #(.N(N)) u_grp (
            .g_i   (g[gi*GROUP +: N]),
            .p_i   (p[gi*GROUP +: N]),
            .cin_i (grp_c[gi]),
            .c_o   (c[gi*GROUP +: N]),
            .gg_o  (grp_g[gi]),
            .gp_o  (grp_p[gi])
        );
    end

    // Second level: lookahead over group G/P gives every group carry-in.
    cla_group #(.N(NG)) u_lvl2 (
        .g_i   (grp_g),
        .p_i   (grp_p),
        .cin_i (CIN),
        .c_o   (grp_c),
        .gg_o  (top_g),
        .gp_o  (top_p)
    );

    // Sum bits and carry out of the whole word.
    always_comb begin
        res_d           = '0;
        res_d.s         = p ^ c;
        res_d.carry_out = top_g | (top_p & CIN);
    end

    // Output register: capture only on valid input, otherwise hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_q <= '0;
            vld_q <= 1'b0;
        end else begin
            vld_q <= in_valid;
            if (in_valid) res_q <= res_d;
        end
    end

    assign s         = res_q.s;
    assign carry_out = res_q.carry_out;
    assign out_valid = vld_q;

endmodule

// File: tb/tb_final_adder.sv
// Directed and random checks of final_adder against a plain a+b model.
module tb_final_adder;
    import final_adder_pkg::*;

    localparam int W = DEF_WIDTH;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [W-1:0] a, b;
    logic         in_valid;
    logic [W-1:0] s;
    logic         carry_out;
    logic         out_valid;

    int   total = 0;
    int   bad   = 0;
    sum_t exp_q[$];
    sum_t hold;

    final_adder #(.WIDTH(W), .GROUP(DEF_GROUP)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .a         (a),
        .b         (b),
        .in_valid  (in_valid),
        .s         (s),
        .carry_out (carry_out),
        .out_valid (out_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One cycle: drive at negedge, check registered outputs just after posedge.
    task automatic step(input logic [W-1:0] av, input logic [W-1:0] bv,
                        input logic v, input string tag);
        @(negedge clk);
        a        = v ? av : 'x;
        b        = v ? bv : 'x;
        in_valid = v;
        if (v) exp_q.push_back(sum_t'({1'b0, av} + {1'b0, bv}));
        @(posedge clk);
        #1;
        chk({tag, "_vld"}, 32'(out_valid), 32'(v));
        if (v) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $error("FAIL %s_queue observed=empty expected=entry", tag);
            end else begin
                hold = exp_q.pop_front();
            end
        end
        chk(tag, 32'({carry_out, s}), 32'(hold));
    endtask

    initial begin
        rst_n    = 1'b0;
        a        = 'x;
        b        = 'x;
        in_valid = 1'b1;
        hold     = '0;
        #2;
        chk("reset_async", 32'({out_valid, carry_out, s}), 32'd0);
        @(posedge clk);
        #1;
        chk("reset_held", 32'({out_valid, carry_out, s}), 32'd0);
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b1;

        // Directed vectors, back to back
        step(10'h03C, 10'h003, 1'b1, "small");
        step(10'h3FF, 10'h001, 1'b1, "full_chain");
        step(10'h155, 10'h2AA, 1'b1, "alt_bits");
        step(10'h000, 10'h000, 1'b1, "zero");
        step(10'h3FF, 10'h3FF, 1'b1, "max_max");
        step(10'h00F, 10'h001, 1'b1, "grp0_carry");
        step(10'h0F0, 10'h010, 1'b1, "grp1_carry");
        step(10'h200, 10'h200, 1'b1, "msb_only");
        step(10'h000, 10'h000, 1'b0, "hold1");
        step(10'h000, 10'h000, 1'b0, "hold2");
        step(10'h123, 10'h0DD, 1'b1, "after_hold");

        // Mid-stream asynchronous reset
        step(10'h3FF, 10'h3FF, 1'b1, "pre_reset");
        @(negedge clk);
        a        = 10'h3FF;
        b        = 10'h3FF;
        in_valid = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        chk("reset_mid", 32'({out_valid, carry_out, s}), 32'd0);
        @(posedge clk);
        #1;
        chk("reset_mid_edge", 32'({out_valid, carry_out, s}), 32'd0);
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b1;
        hold     = '0;
        exp_q.delete();
        step(10'h000, 10'h000, 1'b0, "post_reset1");
        step(10'h000, 10'h000, 1'b0, "post_reset2");

        // Random sweep, invalid cycles drive X operands
        for (int n = 0; n < 10000; n++) begin
            step(W'($urandom), W'($urandom), ($urandom_range(0, 3) != 0), "rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
